// File: rtl/ctrl_pkg.sv
// Shared opcodes, FSM state encoding and instruction-class types for the multicycle control.
package ctrl_pkg;

    localparam logic [6:0] OP_ARTH  = 7'b0110011;
    localparam logic [6:0] OP_ADDI  = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_ALU   = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        CL_NONE    = 3'd0,
        CL_R       = 3'd1,
        CL_ADDI    = 3'd2,
        CL_LOAD    = 3'd3,
        CL_STORE   = 3'd4,
        CL_BR      = 3'd5,
        CL_JAL     = 3'd6,
        CL_ILLEGAL = 3'd7
    } class_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_OR  = 2'd2,
        ALU_AND = 2'd3
    } alu_op_t;

    typedef struct packed {
        class_t  cls;
        alu_op_t alu;
    } decode_t;

    // ALU control bundle {BSEL, CISEL, LogicalOp, LOGICAL_OA} for an R-type operation
    function automatic logic [3:0] alu_ctl(input alu_op_t op);
        logic [3:0] ctl;
        ctl = 4'b0000;
        case (op)
            ALU_SUB: ctl = 4'b1100;
            ALU_OR:  ctl = 4'b0010;
            ALU_AND: ctl = 4'b0011;
            default: ctl = 4'b0000;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/ctrl_classify.sv
// Combinational instruction classifier: opcode/funct fields -> class and ALU operation.
module ctrl_classify
    import ctrl_pkg::*;
#(
    parameter int unsigned EN_JAL = 1,
    parameter int unsigned EN_SUB = 1
)(
    input  logic [6:0] i_op,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    output decode_t    o_dec
);

    // Anything not explicitly recognised falls through to ILLEGAL
    always_comb begin
        o_dec.cls = CL_ILLEGAL;
        o_dec.alu = ALU_ADD;
        case (i_op)
            OP_ARTH: begin
                case (i_funct3)
                    3'b000: begin
                        o_dec.cls = CL_R;
                        o_dec.alu = ((EN_SUB != 0) && (i_funct7 != 7'd0)) ? ALU_SUB : ALU_ADD;
                    end
                    3'b110: begin
                        o_dec.cls = CL_R;
                        o_dec.alu = ALU_OR;
                    end
                    3'b111: begin
                        o_dec.cls = CL_R;
                        o_dec.alu = ALU_AND;
                    end
                    default: o_dec.cls = CL_ILLEGAL;
                endcase
            end
            OP_ADDI:  o_dec.cls = CL_ADDI;
            OP_LOAD:  o_dec.cls = CL_LOAD;
            OP_STORE: o_dec.cls = CL_STORE;
            OP_BR:    o_dec.cls = (i_funct3 == 3'b000) ? CL_BR : CL_ILLEGAL;
            OP_JAL:   o_dec.cls = (EN_JAL != 0) ? CL_JAL : CL_ILLEGAL;
            default:  o_dec.cls = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32 control FSM: sequences fetch/decode/execute/memory/write-back with a
// memory handshake, wait timeout and sticky fault trap.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned EN_JAL      = 1,
    parameter int unsigned EN_SUB      = 1
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [6:0] OP,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       mem_ready,
    input  logic       zero,
    output logic       PCWrite,
    output logic       PCSrc,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       MemtoReg,
    output logic       ALUSrc,
    output logic       BSEL,
    output logic       CISEL,
    output logic       LogicalOp,
    output logic       LOGICAL_OA,
    output logic       Branch,
    output logic       Jump,
    output logic       fault,
    output logic [3:0] state_o
);

    localparam int unsigned     CNT_W   = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MEM_TIMEOUT);

    state_t           r_state;
    state_t           w_next;
    class_t           r_class;
    alu_op_t          r_alu;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_fault;
    decode_t          w_dec;
    logic             w_mem_state;
    logic             w_timeout;
    logic             w_wait_clr;

    ctrl_classify #(
        .EN_JAL (EN_JAL),
        .EN_SUB (EN_SUB)
    ) u_classify (
        .i_op     (OP),
        .i_funct3 (funct3),
        .i_funct7 (funct7),
        .o_dec    (w_dec)
    );

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    assign w_timeout   = (MEM_TIMEOUT != 0) && w_mem_state && !mem_ready && (r_wait_cnt == CNT_LIM);
    assign w_wait_clr  = (w_next != r_state) &&
                         ((w_next == S_FETCH) || (w_next == S_MEM_RD) || (w_next == S_MEM_WR));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Latch the decoded class and ALU operation for use by the later states
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_class <= CL_NONE;
            r_alu   <= ALU_ADD;
        end else if (r_state == S_DECODE) begin
            r_class <= w_dec.cls;
            r_alu   <= w_dec.alu;
        end
    end

    // Memory wait counter: restarts on entering a memory state, saturates while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (w_wait_clr) begin
            r_wait_cnt <= '0;
        end else if (w_mem_state && !mem_ready && (r_wait_cnt != CNT_MAX)) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    // Sticky fault, set on any entry into TRAP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else if (w_next == S_TRAP) begin
            r_fault <= 1'b1;
        end
    end

    // Next-state and Moore output decode (FETCH write strobes gated by mem_ready)
    always_comb begin
        w_next     = r_state;
        PCWrite    = 1'b0;
        PCSrc      = 1'b0;
        IRWrite    = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrc     = 1'b0;
        BSEL       = 1'b0;
        CISEL      = 1'b0;
        LogicalOp  = 1'b0;
        LOGICAL_OA = 1'b0;
        Branch     = 1'b0;
        Jump       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (run) w_next = S_FETCH;
            end
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready)      w_next = S_DECODE;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_DECODE: begin
                case (w_dec.cls)
                    CL_R:     w_next = S_EXEC_R;
                    CL_ADDI:  w_next = S_EXEC_I;
                    CL_LOAD:  w_next = S_MEM_ADDR;
                    CL_STORE: w_next = S_MEM_ADDR;
                    CL_BR:    w_next = S_BRANCH;
                    CL_JAL:   w_next = S_JUMP;
                    default:  w_next = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                {BSEL, CISEL, LogicalOp, LOGICAL_OA} = alu_ctl(r_alu);
                w_next = S_WB_ALU;
            end
            S_EXEC_I: begin
                ALUSrc = 1'b1;
                w_next = S_WB_ALU;
            end
            S_WB_ALU: begin
                RegWrite = 1'b1;
                ALUSrc   = (r_class == CL_ADDI);
                {BSEL, CISEL, LogicalOp, LOGICAL_OA} = alu_ctl(r_alu);
                w_next = run ? S_FETCH : S_IDLE;
            end
            S_MEM_ADDR: begin
                ALUSrc = 1'b1;
                w_next = (r_class == CL_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                if (mem_ready)      w_next = S_WB_MEM;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_WB_MEM: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                w_next   = run ? S_FETCH : S_IDLE;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                if (mem_ready)      w_next = run ? S_FETCH : S_IDLE;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_BRANCH: begin
                Branch  = 1'b1;
                BSEL    = 1'b1;
                CISEL   = 1'b1;
                PCWrite = zero;
                PCSrc   = 1'b1;
                w_next  = run ? S_FETCH : S_IDLE;
            end
            S_JUMP: begin
                Jump     = 1'b1;
                PCWrite  = 1'b1;
                PCSrc    = 1'b1;
                RegWrite = 1'b1;
                w_next   = run ? S_FETCH : S_IDLE;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign fault   = r_fault;
    assign state_o = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
module tb_multicycle_control;
    import ctrl_pkg::*;

    logic       clk;
    logic       reset;
    logic       run;
    logic [6:0] OP;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       mem_ready;
    logic       zero;
    logic       PCWrite, PCSrc, IRWrite, MemRead, MemWrite, RegWrite, MemtoReg;
    logic       ALUSrc, BSEL, CISEL, LogicalOp, LOGICAL_OA, Branch, Jump, fault;
    logic [3:0] state_o;
    logic [14:0] w_outs;

    int n_checks = 0;
    int n_err    = 0;

    localparam logic [14:0] O_NONE = 15'h0000;
    localparam logic [14:0] PCW  = 15'h4000;
    localparam logic [14:0] PCS  = 15'h2000;
    localparam logic [14:0] IRW  = 15'h1000;
    localparam logic [14:0] MRD  = 15'h0800;
    localparam logic [14:0] MWR  = 15'h0400;
    localparam logic [14:0] RGW  = 15'h0200;
    localparam logic [14:0] M2R  = 15'h0100;
    localparam logic [14:0] ASRC = 15'h0080;
    localparam logic [14:0] BSL  = 15'h0040;
    localparam logic [14:0] CIS  = 15'h0020;
    localparam logic [14:0] LOP  = 15'h0010;
    localparam logic [14:0] LOA  = 15'h0008;
    localparam logic [14:0] BRO  = 15'h0004;
    localparam logic [14:0] JMP  = 15'h0002;
    localparam logic [14:0] FLT  = 15'h0001;
    localparam logic [14:0] FET  = MRD | IRW | PCW;

    multicycle_control #(
        .MEM_TIMEOUT (15),
        .EN_JAL      (1),
        .EN_SUB      (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .OP         (OP),
        .funct3     (funct3),
        .funct7     (funct7),
        .mem_ready  (mem_ready),
        .zero       (zero),
        .PCWrite    (PCWrite),
        .PCSrc      (PCSrc),
        .IRWrite    (IRWrite),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .MemtoReg   (MemtoReg),
        .ALUSrc     (ALUSrc),
        .BSEL       (BSEL),
        .CISEL      (CISEL),
        .LogicalOp  (LogicalOp),
        .LOGICAL_OA (LOGICAL_OA),
        .Branch     (Branch),
        .Jump       (Jump),
        .fault      (fault),
        .state_o    (state_o)
    );

    assign w_outs = {PCWrite, PCSrc, IRWrite, MemRead, MemWrite, RegWrite, MemtoReg,
                     ALUSrc, BSEL, CISEL, LogicalOp, LOGICAL_OA, Branch, Jump, fault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic reset_pulse();
        @(negedge clk);
        reset = 1'b1;
        run   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_checks++;
        if (state_o !== 4'(S_IDLE) || w_outs !== O_NONE) begin
            n_err++;
            $display("FAIL reset_hold state=%0d exp=%0d outs=%h exp=%h", state_o, S_IDLE, w_outs, O_NONE);
        end
        reset = 1'b0;
        run   = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (state_o !== 4'(S_IDLE) || w_outs !== O_NONE) begin
            n_err++;
            $display("FAIL idle_run0 state=%0d exp=%0d outs=%h exp=%h", state_o, S_IDLE, w_outs, O_NONE);
        end
    endtask

    task automatic test_add_sub();
        state_t      es [10] = '{S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_ALU,
                                 S_FETCH, S_DECODE, S_EXEC_R, S_WB_ALU, S_IDLE};
        logic [14:0] eo [10] = '{O_NONE, FET, O_NONE, O_NONE, RGW,
                                 FET, O_NONE, BSL | CIS, RGW | BSL | CIS, O_NONE};
        reset_pulse();
        OP = OP_ARTH;
        funct3 = 3'b000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            run       = (i != 8);
            mem_ready = 1'b1;
            zero      = 1'b0;
            funct7    = (i >= 4) ? 7'h20 : 7'h00;
            #1;
            n_checks++;
            if (state_o !== 4'(es[i]) || w_outs !== eo[i]) begin
                n_err++;
                $display("FAIL add_sub cyc=%0d state=%0d exp=%0d outs=%h exp=%h", i, state_o, es[i], w_outs, eo[i]);
            end
        end
    endtask

    task automatic test_logic_ops();
        state_t      es [9] = '{S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_ALU,
                                S_FETCH, S_DECODE, S_EXEC_R, S_WB_ALU};
        logic [14:0] eo [9] = '{O_NONE, FET, O_NONE, LOP, RGW | LOP,
                                FET, O_NONE, LOP | LOA, RGW | LOP | LOA};
        reset_pulse();
        OP = OP_ARTH;
        funct7 = 7'h20;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            run       = (i != 8);
            mem_ready = 1'b1;
            funct3    = (i >= 4) ? 3'b111 : 3'b110;
            #1;
            n_checks++;
            if (state_o !== 4'(es[i]) || w_outs !== eo[i]) begin
                n_err++;
                $display("FAIL or_and cyc=%0d state=%0d exp=%0d outs=%h exp=%h", i, state_o, es[i], w_outs, eo[i]);
            end
        end
    endtask

    task automatic test_load_wait();
        state_t      es [10] = '{S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD,
                                 S_MEM_RD, S_MEM_RD, S_MEM_RD, S_WB_MEM, S_IDLE};
        logic [14:0] eo [10] = '{O_NONE, FET, O_NONE, ASRC, MRD,
                                 MRD, MRD, MRD, RGW | M2R, O_NONE};
        bit          rdy [10] = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1};
        reset_pulse();
        OP = OP_LOAD;
        funct3 = 3'b010;
        funct7 = 7'h00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            run       = (i != 8);
            mem_ready = rdy[i];
            #1;
            n_checks++;
            if (state_o !== 4'(es[i]) || w_outs !== eo[i]) begin
                n_err++;
                $display("FAIL load_wait cyc=%0d state=%0d exp=%0d outs=%h exp=%h", i, state_o, es[i], w_outs, eo[i]);
            end
        end
    endtask

    task automatic test_branch();
        state_t      es [8] = '{S_IDLE, S_FETCH, S_DECODE, S_BRANCH,
                                S_FETCH, S_DECODE, S_BRANCH, S_IDLE};
        logic [14:0] eo [8] = '{O_NONE, FET, O_NONE, BRO | BSL | CIS | PCW | PCS,
                                FET, O_NONE, BRO | BSL | CIS | PCS, O_NONE};
        reset_pulse();
        OP = OP_BR;
        funct3 = 3'b000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            run       = (i != 6);
            mem_ready = 1'b1;
            zero      = (i < 4);
            #1;
            n_checks++;
            if (state_o !== 4'(es[i]) || w_outs !== eo[i]) begin
                n_err++;
                $display("FAIL beq cyc=%0d state=%0d exp=%0d outs=%h exp=%h", i, state_o, es[i], w_outs, eo[i]);
            end
        end
    endtask

    task automatic test_jal_addi_store();
        state_t      es [13] = '{S_IDLE, S_FETCH, S_DECODE, S_JUMP,
                                 S_FETCH, S_DECODE, S_EXEC_I, S_WB_ALU,
                                 S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_WR, S_IDLE};
        logic [14:0] eo [13] = '{O_NONE, FET, O_NONE, JMP | PCW | PCS | RGW,
                                 FET, O_NONE, ASRC, RGW | ASRC,
                                 FET, O_NONE, ASRC, MWR, O_NONE};
        reset_pulse();
        funct3 = 3'b000;
        funct7 = 7'h00;
        zero   = 1'b0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            run       = (i != 11);
            mem_ready = 1'b1;
            OP        = (i < 3) ? OP_JAL : ((i < 7) ? OP_ADDI : OP_STORE);
            #1;
            n_checks++;
            if (state_o !== 4'(es[i]) || w_outs !== eo[i]) begin
                n_err++;
                $display("FAIL jal_addi_st cyc=%0d state=%0d exp=%0d outs=%h exp=%h", i, state_o, es[i], w_outs, eo[i]);
            end
        end
    endtask

    task automatic test_timeout();
        state_t      exp_s;
        logic [14:0] exp_o;
        reset_pulse();
        OP = OP_ARTH;
        funct3 = 3'b000;
        funct7 = 7'h00;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            run       = 1'b1;
            mem_ready = (i >= 18);
            exp_s     = (i == 0) ? S_IDLE : ((i <= 16) ? S_FETCH : S_TRAP);
            exp_o     = (i == 0) ? O_NONE : ((i <= 16) ? MRD : FLT);
            #1;
            n_checks++;
            if (state_o !== 4'(exp_s) || w_outs !== exp_o) begin
                n_err++;
                $display("FAIL timeout cyc=%0d state=%0d exp=%0d outs=%h exp=%h", i, state_o, exp_s, w_outs, exp_o);
            end
        end
        reset_pulse();
        #1;
        n_checks++;
        if (state_o !== 4'(S_IDLE) || w_outs !== O_NONE) begin
            n_err++;
            $display("FAIL fault_clear state=%0d exp=%0d outs=%h exp=%h", state_o, S_IDLE, w_outs, O_NONE);
        end
    endtask

    task automatic test_no_timeout();
        state_t      exp_s;
        logic [14:0] exp_o;
        reset_pulse();
        OP = OP_ARTH;
        funct3 = 3'b000;
        funct7 = 7'h00;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            run       = 1'b1;
            mem_ready = (i == 0) || (i >= 16);
            exp_s     = (i == 0) ? S_IDLE : ((i <= 16) ? S_FETCH : ((i == 17) ? S_DECODE : S_EXEC_R));
            exp_o     = (i == 0) ? O_NONE : ((i <= 15) ? MRD : ((i == 16) ? FET : O_NONE));
            #1;
            n_checks++;
            if (state_o !== 4'(exp_s) || w_outs !== exp_o) begin
                n_err++;
                $display("FAIL ready_at_limit cyc=%0d state=%0d exp=%0d outs=%h exp=%h", i, state_o, exp_s, w_outs, exp_o);
            end
        end
    endtask

    task automatic test_illegal();
        state_t      es [6] = '{S_IDLE, S_FETCH, S_DECODE, S_TRAP, S_TRAP, S_TRAP};
        logic [14:0] eo [6] = '{O_NONE, FET, O_NONE, FLT, FLT, FLT};
        for (int k = 0; k < 2; k++) begin
            reset_pulse();
            OP     = (k == 0) ? 7'h7F : OP_ARTH;
            funct3 = (k == 0) ? 3'b000 : 3'b001;
            funct7 = 7'h00;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                run       = 1'b1;
                mem_ready = 1'b1;
                #1;
                n_checks++;
                if (state_o !== 4'(es[i]) || w_outs !== eo[i]) begin
                    n_err++;
                    $display("FAIL illegal k=%0d cyc=%0d state=%0d exp=%0d outs=%h exp=%h", k, i, state_o, es[i], w_outs, eo[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_memrd();
        state_t      es [5] = '{S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD};
        logic [14:0] eo [5] = '{O_NONE, FET, O_NONE, ASRC, MRD};
        reset_pulse();
        OP = OP_LOAD;
        funct3 = 3'b010;
        funct7 = 7'h00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            run       = 1'b1;
            mem_ready = (i < 4);
            #1;
            n_checks++;
            if (state_o !== 4'(es[i]) || w_outs !== eo[i]) begin
                n_err++;
                $display("FAIL rst_mid cyc=%0d state=%0d exp=%0d outs=%h exp=%h", i, state_o, es[i], w_outs, eo[i]);
            end
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (state_o !== 4'(S_IDLE) || w_outs !== O_NONE) begin
            n_err++;
            $display("FAIL rst_async state=%0d exp=%0d outs=%h exp=%h", state_o, S_IDLE, w_outs, O_NONE);
        end
        @(negedge clk);
        reset     = 1'b0;
        run       = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (state_o !== 4'(S_FETCH) || w_outs !== FET) begin
            n_err++;
            $display("FAIL rst_refetch state=%0d exp=%0d outs=%h exp=%h", state_o, S_FETCH, w_outs, FET);
        end
    endtask

    initial begin
        reset     = 1'b1;
        run       = 1'b0;
        OP        = 7'h00;
        funct3    = 3'b000;
        funct7    = 7'h00;
        mem_ready = 1'b0;
        zero      = 1'b0;
        test_reset();
        test_add_sub();
        test_logic_ops();
        test_load_wait();
        test_branch();
        test_jal_addi_store();
        test_timeout();
        test_no_timeout();
        test_illegal();
        test_reset_mid_memrd();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
